keypad_scanner: RTL

//  Row-scanning controller for the 4x4 matrix keypad on the clk_10m domain.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/keypad_scanner.sv | 131 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and column helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} kp_state_t;

    localparam int          N_ROWS   = 4;
    localparam int          N_COLS   = 4;
    localparam logic [3:0]  ROW_IDLE = 4'b1111;

    // Index of the lowest-numbered low (pressed) column.
    function automatic logic [1:0] lowest_low(input logic [N_COLS-1:0] cols);
        lowest_low = 2'd0;
        for (int i = N_COLS - 1; i >= 0; i--) begin
            if (!cols[i]) lowest_low = 2'(i);
        end
    endfunction

    function automatic logic multi_low(input logic [N_COLS-1:0] cols);
        logic [N_COLS-1:0] low;
        low       = ~cols;
        multi_low = (low & (low - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all-ones
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with press/release debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 100,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       multi_key
);

    localparam int RW = $clog2(N_ROWS);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [3:0]       cols;
    kp_state_t        state, nxt_state;
    logic [RW-1:0]    row_idx, nxt_row;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [3:0]       pat, nxt_pat;
    logic             nxt_valid, nxt_held, nxt_multi;
    logic [3:0]       nxt_code;

    sync_2ff #(.W(4)) u_col_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (col_n),
        .q    (cols)
    );

    always_comb begin
        row_n = ROW_IDLE & ~(4'b0001 << row_idx);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SCAN;
            row_idx   <= '0;
            cnt       <= '0;
            pat       <= ROW_IDLE;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= nxt_state;
            row_idx   <= nxt_row;
            cnt       <= nxt_cnt;
            pat       <= nxt_pat;
            key_valid <= nxt_valid;
            key_code  <= nxt_code;
            key_held  <= nxt_held;
            multi_key <= nxt_multi;
        end
    end

    // Counters only increment below their terminal value, so they never wrap.
    always_comb begin
        nxt_state = state;
        nxt_row   = row_idx;
        nxt_cnt   = cnt;
        nxt_pat   = pat;
        nxt_valid = 1'b0;
        nxt_code  = key_code;
        nxt_held  = key_held;
        nxt_multi = multi_key;
        case (state)
            SCAN: begin
                if (cnt == SETTLE_LAST) begin
                    nxt_cnt = '0;
                    if (cols == ROW_IDLE) begin
                        nxt_row = row_idx + 1'b1;
                    end else begin
                        nxt_pat   = cols;
                        nxt_state = DEB_PRESS;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            DEB_PRESS: begin
                if (cols == ROW_IDLE) begin
                    nxt_state = SCAN;
                    nxt_row   = row_idx + 1'b1;
                    nxt_cnt   = '0;
                end else if (cols != pat) begin
                    nxt_pat = cols;
                    nxt_cnt = '0;
                end else if (cnt == DEB_LAST) begin
                    nxt_valid = 1'b1;
                    nxt_code  = {row_idx, lowest_low(pat)};
                    nxt_held  = 1'b1;
                    nxt_multi = multi_low(pat);
                    nxt_state = PRESSED;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (cols == ROW_IDLE) begin
                    nxt_state = DEB_RELEASE;
                    nxt_cnt   = '0;
                end
            end
            DEB_RELEASE: begin
                if (cols != ROW_IDLE) begin
                    nxt_state = PRESSED;
                    nxt_cnt   = '0;
                end else if (cnt == DEB_LAST) begin
                    nxt_held  = 1'b0;
                    nxt_state = SCAN;
                    nxt_row   = row_idx + 1'b1;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt + CNT_ONE;
                end
            end
            default: nxt_state = SCAN;
        endcase
    end

endmodule
